// File: rtl/mfp_sevenseg_pkg.sv
// Shared definitions for the seven-segment scan driver: glyph codes,
// active-low segment patterns ({g,f,e,d,c,b,a}) and the scan state encoding.
// Optional build macro used by the top: SEVSEG_DIM_EN (brightness control).
package mfp_sevenseg_pkg;

    // Scan state: BLANK holds every anode off, ACTIVE drives the current digit.
    typedef enum logic {
        ST_BLANK  = 1'b0,
        ST_ACTIVE = 1'b1
    } scan_state_e;

    // Special glyph codes (codes 0x00-0x0F are the hex digits).
    localparam logic [4:0] GLY_BLANK = 5'h10;
    localparam logic [4:0] GLY_MINUS = 5'h11;
    localparam logic [4:0] GLY_UNDER = 5'h12;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_UNDER = 7'h77;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    // All anodes released (common-anode display, active-low drive).
    localparam logic [7:0] AN_OFF = 8'hFF;

    // Active-low one-hot anode select for digit position idx.
    function automatic logic [7:0] anode_sel_n(input logic [2:0] idx);
        logic [7:0] onehot;
        onehot = 8'b0000_0001 << idx;
        return ~onehot;
    endfunction

endpackage : mfp_sevenseg_pkg

// File: rtl/mfp_sevenseg_glyph_decode.sv
// Combinational glyph decoder: 5-bit glyph code -> 7-bit active-low segment
// pattern. Unassigned codes (0x10, 0x13-0x1F) decode to a dark digit.
module mfp_sevenseg_glyph_decode
    import mfp_sevenseg_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg_n
);

    // Map each glyph code to its segment pattern; anything unknown is blank.
    always_comb begin
        seg_n = SEG_OFF;
        case (code)
            5'h00:     seg_n = SEG_0;
            5'h01:     seg_n = SEG_1;
            5'h02:     seg_n = SEG_2;
            5'h03:     seg_n = SEG_3;
            5'h04:     seg_n = SEG_4;
            5'h05:     seg_n = SEG_5;
            5'h06:     seg_n = SEG_6;
            5'h07:     seg_n = SEG_7;
            5'h08:     seg_n = SEG_8;
            5'h09:     seg_n = SEG_9;
            5'h0A:     seg_n = SEG_A;
            5'h0B:     seg_n = SEG_B;
            5'h0C:     seg_n = SEG_C;
            5'h0D:     seg_n = SEG_D;
            5'h0E:     seg_n = SEG_E;
            5'h0F:     seg_n = SEG_F;
            GLY_MINUS: seg_n = SEG_MINUS;
            GLY_UNDER: seg_n = SEG_UNDER;
            default:   seg_n = SEG_OFF;
        endcase
    end

endmodule : mfp_sevenseg_glyph_decode

// File: rtl/mfp_sevenseg_scan_driver.sv
// Eight-digit common-anode scan driver. Each digit owns SCAN_DIV clock slots,
// the first BLANK_CYC of which keep all anodes off to stop ghosting between
// digits. Inputs are snapshotted once per frame (slot 0, count 0) so a CPU
// write in the middle of a scan never shows a half-updated frame. All pins are
// registered and lag the slot counters by one cycle.
// Optional build macro: SEVSEG_DIM_EN adds a 4-bit brightness input that
// gates the anode with a 16-phase PWM inside each ACTIVE window.
module mfp_sevenseg_scan_driver
    import mfp_sevenseg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 64
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [7:0]  en,
    input  logic [63:0] digits,
    input  logic [7:0]  dp,
`ifdef SEVSEG_DIM_EN
    input  logic [3:0]  bright,
`endif
    output logic [7:0]  IO_7SEGEN_N,
    output logic [6:0]  IO_7SEG_N,
    output logic        IO_7SEG_DP
);

    localparam int              CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    // Slot counter, digit index and scan state.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    scan_state_e      state_q, state_d;

    // Frame shadows of the CPU-side registers.
    logic [7:0]       shadow_en_q, shadow_en_d;
    logic [63:0]      shadow_dig_q, shadow_dig_d;
    logic [7:0]       shadow_dp_q, shadow_dp_d;
`ifdef SEVSEG_DIM_EN
    logic [3:0]       shadow_bright_q, shadow_bright_d;
    logic [3:0]       ph_s;
`endif

    // Registered pin drivers.
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dpo_q, dpo_d;

    logic             cnt_wrap_s;
    logic             snap_s;
    logic [4:0]       glyph_code_s;
    logic [6:0]       glyph_seg_s;
    logic             an_gate_s;

    // Glyph of the digit currently being scanned; bits [7:5] of each byte are don't-care.
    assign glyph_code_s = shadow_dig_q[{idx_q, 3'b000} +: 5];

    mfp_sevenseg_glyph_decode u_glyph_decode (
        .code  (glyph_code_s),
        .seg_n (glyph_seg_s)
    );

    // Slot counter wraps every SCAN_DIV cycles and steps the digit index.
    always_comb begin
        cnt_wrap_s = (cnt_q == CNT_LAST);
        if (cnt_wrap_s) begin
            cnt_d = {CNT_W{1'b0}};
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            idx_d = idx_q;
        end
    end

    // Capture the inputs only at frame start so a frame is always coherent.
    always_comb begin
        snap_s = (cnt_q == {CNT_W{1'b0}}) && (idx_q == 3'd0);
        if (snap_s) begin
            shadow_en_d  = en;
            shadow_dig_d = digits;
            shadow_dp_d  = dp;
        end else begin
            shadow_en_d  = shadow_en_q;
            shadow_dig_d = shadow_dig_q;
            shadow_dp_d  = shadow_dp_q;
        end
    end

`ifdef SEVSEG_DIM_EN
    // Brightness is part of the frame snapshot; PWM phase restarts at each ACTIVE window.
    always_comb begin
        if (snap_s) begin
            shadow_bright_d = bright;
        end else begin
            shadow_bright_d = shadow_bright_q;
        end
        ph_s      = 4'(cnt_q - BLANK_LIM);
        an_gate_s = (ph_s <= shadow_bright_q);
    end
`else
    // Without dimming the digit is lit for the whole ACTIVE window.
    always_comb begin
        an_gate_s = 1'b1;
    end
`endif

    // Next state follows the next count, so state_q always describes cnt_q.
    always_comb begin
        if (cnt_d < BLANK_LIM) begin
            state_d = ST_BLANK;
        end else begin
            state_d = ST_ACTIVE;
        end
    end

    // Pin values for the next cycle, derived from the present counters and shadows.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dpo_d = 1'b1;
        case (state_q)
            ST_BLANK: begin
                an_d  = AN_OFF;
                seg_d = SEG_OFF;
                dpo_d = 1'b1;
            end
            ST_ACTIVE: begin
                if (an_gate_s) begin
                    an_d = anode_sel_n(idx_q) | shadow_en_q;
                end else begin
                    an_d = AN_OFF;
                end
                seg_d = glyph_seg_s;
                dpo_d = shadow_dp_q[idx_q];
            end
            default: begin
                an_d  = AN_OFF;
                seg_d = SEG_OFF;
                dpo_d = 1'b1;
            end
        endcase
    end

    // Scan state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, frame shadows and output registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q           <= {CNT_W{1'b0}};
            idx_q           <= 3'd0;
            shadow_en_q     <= 8'hFF;
            shadow_dig_q    <= 64'h0;
            shadow_dp_q     <= 8'hFF;
`ifdef SEVSEG_DIM_EN
            shadow_bright_q <= 4'hF;
`endif
            an_q            <= AN_OFF;
            seg_q           <= SEG_OFF;
            dpo_q           <= 1'b1;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            shadow_en_q     <= shadow_en_d;
            shadow_dig_q    <= shadow_dig_d;
            shadow_dp_q     <= shadow_dp_d;
`ifdef SEVSEG_DIM_EN
            shadow_bright_q <= shadow_bright_d;
`endif
            an_q            <= an_d;
            seg_q           <= seg_d;
            dpo_q           <= dpo_d;
        end
    end

    assign IO_7SEGEN_N = an_q;
    assign IO_7SEG_N   = seg_q;
    assign IO_7SEG_DP  = dpo_q;

endmodule : mfp_sevenseg_scan_driver
